// File: rtl/hw_accel_edge_detection_mk2.sv
// Streaming 3x3 gradient edge detector (Sobel/Prewitt/Scharr) with an internal two-line buffer and self-flushing tail.
// Latency: 3 cycles from launch to pixel_out_valid. Input backpressure only during FLUSH/DRAIN; no output backpressure.
module hw_accel_edge_detection_mk2 #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_IMG_WIDTH  = 1920,
    parameter int MAX_IMG_HEIGHT = 1080
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [$clog2(MAX_IMG_WIDTH+1)-1:0]  cfg_img_width,
    input  logic [$clog2(MAX_IMG_HEIGHT+1)-1:0] cfg_img_height,
    input  logic [1:0]                          cfg_kernel,
    input  logic                                cfg_mag_max,
    input  logic                                cfg_gray_out,
    input  logic [DATA_WIDTH-1:0]               cfg_thresh,
    input  logic [DATA_WIDTH-1:0]               pixel_in,
    input  logic                                pixel_in_valid,
    output logic                                pixel_in_ready,
    output logic [DATA_WIDTH-1:0]               pixel_out,
    output logic                                pixel_out_valid,
    output logic                                frame_done
);
    localparam int DW = DATA_WIDTH;
    localparam int WW = $clog2(MAX_IMG_WIDTH + 1);
    localparam int HW = $clog2(MAX_IMG_HEIGHT + 1);
    localparam int AW = $clog2(MAX_IMG_WIDTH);
    localparam int CW = $clog2(MAX_IMG_WIDTH * MAX_IMG_HEIGHT + 1);
    localparam int GW = DW + 6;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [WW-1:0]           w_q, w_d, x_q, x_d, fl_cnt_q, fl_cnt_d, ox_q, ox_d;
    logic [HW-1:0]           h_q, h_d, oy_q, oy_d;
    logic [CW-1:0]           area_q, area_d, in_cnt_q, in_cnt_d;
    logic [1:0]              kern_q, kern_d;
    logic                    mag_max_q, mag_max_d, gray_q, gray_d, in_rdy_q, in_rdy_d;
    logic [DW-1:0]           thresh_q, thresh_d;
    logic [2:0][DW-1:0]      win1_q, win1_d, win2_q, win2_d;
    logic                    v1_q, v1_d, bord1_q, bord1_d, last1_q, last1_d;
    logic signed [GW-1:0]    gx_q, gx_d, gy_q, gy_d;
    logic                    v2_q, v2_d, bord2_q, bord2_d, last2_q, last2_d;
    logic [GW-1:0]           mag_q, mag_d;
    logic [DW-1:0]           out_q, out_d;
    logic                    out_vld_q, out_vld_d, done_q, done_d;

    logic                    accept, launch, shift;
    logic [WW-1:0]           wr_x, w_eff, x_inc;
    logic [2:0][DW-1:0]      tap;
    logic signed [GW-1:0]    wa, wb;
    logic [GW-1:0]           ax, ay;
    logic [DW-1:0]           sat, bin;

    logic [DW-1:0] lb_top_mem [MAX_IMG_WIDTH];
    logic [DW-1:0] lb_mid_mem [MAX_IMG_WIDTH];

    function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] p);
        return $signed({{(GW-DW){1'b0}}, p});
    endfunction

    // Line buffer: mid holds the previous row, top the row before that, both indexed by column.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mid_mem[wr_x[AW-1:0]] <= pixel_in;
            lb_top_mem[wr_x[AW-1:0]] <= lb_mid_mem[wr_x[AW-1:0]];
        end
    end

    assign accept = pixel_in_valid && in_rdy_q;
    assign wr_x   = (state_q == S_IDLE) ? '0 : x_q;
    assign w_eff  = (state_q == S_IDLE) ? cfg_img_width : w_q;
    assign x_inc  = wr_x + WW'(1);
    assign tap    = {pixel_in, lb_mid_mem[wr_x[AW-1:0]], lb_top_mem[wr_x[AW-1:0]]};
    assign shift  = accept || (state_q == S_FLUSH);

    always_comb begin
        state_d = state_q;   w_d = w_q;       h_d = h_q;        area_d = area_q;
        kern_d = kern_q;     mag_max_d = mag_max_q;             gray_d = gray_q;
        thresh_d = thresh_q; in_cnt_d = in_cnt_q;               x_d = x_q;
        fl_cnt_d = fl_cnt_q; ox_d = ox_q;     oy_d = oy_q;
        launch = 1'b0;
        last1_d = 1'b0;
        if (accept)
            x_d = (x_inc >= w_eff) ? '0 : x_inc;
        case (state_q)
            S_IDLE: if (accept) begin
                w_d = cfg_img_width;   h_d = cfg_img_height;
                area_d = CW'(cfg_img_width) * CW'(cfg_img_height);
                kern_d = cfg_kernel;   mag_max_d = cfg_mag_max;
                gray_d = cfg_gray_out; thresh_d = cfg_thresh;
                in_cnt_d = CW'(1);     fl_cnt_d = '0;
                ox_d = '0;             oy_d = '0;
                state_d = S_FILL;
            end
            S_FILL: if (accept) begin
                in_cnt_d = in_cnt_q + CW'(1);
                if (in_cnt_d >= area_q)                     state_d = S_FLUSH;
                else if (in_cnt_d == CW'(w_q) + CW'(1))     state_d = S_RUN;
            end
            S_RUN: if (accept) begin
                launch   = 1'b1;
                in_cnt_d = in_cnt_q + CW'(1);
                if (in_cnt_d >= area_q) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                launch   = 1'b1;
                fl_cnt_d = fl_cnt_q + WW'(1);
                if (fl_cnt_q >= w_q) begin
                    last1_d = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (done_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_rdy_d = (state_d == S_IDLE) || (state_d == S_FILL) || (state_d == S_RUN);
        if (launch) begin
            if (ox_q >= w_q - WW'(1)) begin
                ox_d = '0;
                oy_d = oy_q + HW'(1);
            end else begin
                ox_d = ox_q + WW'(1);
            end
        end

        // Window: tap = column i (right), win1 = i-1 (centre), win2 = i-2 (left); index 0 top, 2 bottom.
        win1_d = shift ? tap    : win1_q;
        win2_d = shift ? win1_q : win2_q;
        case (kern_q)
            2'd1:    begin wa = GW'(1); wb = GW'(1);  end
            2'd2:    begin wa = GW'(3); wb = GW'(10); end
            default: begin wa = GW'(1); wb = GW'(2);  end
        endcase
        v1_d    = launch;
        bord1_d = (ox_q == '0) || (ox_q == w_q - WW'(1)) || (oy_q == '0) || (oy_q == h_q - HW'(1));
        gx_d = wa * (ext(tap[0]) - ext(win2_q[0])) + wb * (ext(tap[1]) - ext(win2_q[1]))
             + wa * (ext(tap[2]) - ext(win2_q[2]));
        gy_d = wa * (ext(win2_q[0]) - ext(win2_q[2])) + wb * (ext(win1_q[0]) - ext(win1_q[2]))
             + wa * (ext(tap[0]) - ext(tap[2]));

        ax      = gx_q[GW-1] ? -gx_q : gx_q;
        ay      = gy_q[GW-1] ? -gy_q : gy_q;
        mag_d   = mag_max_q ? ((ax > ay) ? ax : ay) : (ax + ay);
        v2_d    = v1_q;
        bord2_d = bord1_q;
        last2_d = last1_q;

        sat       = (|mag_q[GW-1:DW]) ? '1 : mag_q[DW-1:0];
        bin       = (mag_q > {{(GW-DW){1'b0}}, thresh_q}) ? '1 : '0;
        out_d     = bord2_q ? '0 : (gray_q ? sat : bin);
        out_vld_d = v2_q;
        done_d    = v2_q && last2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;  w_q <= '0;  h_q <= '0;  area_q <= '0;
            kern_q <= '0;  mag_max_q <= 1'b0;  gray_q <= 1'b0;  thresh_q <= '0;
            in_cnt_q <= '0;  x_q <= '0;  fl_cnt_q <= '0;  ox_q <= '0;  oy_q <= '0;
            in_rdy_q <= 1'b1;  win1_q <= '0;  win2_q <= '0;
            v1_q <= 1'b0;  bord1_q <= 1'b0;  last1_q <= 1'b0;  gx_q <= '0;  gy_q <= '0;
            v2_q <= 1'b0;  bord2_q <= 1'b0;  last2_q <= 1'b0;  mag_q <= '0;
            out_q <= '0;  out_vld_q <= 1'b0;  done_q <= 1'b0;
        end else begin
            state_q <= state_d;  w_q <= w_d;  h_q <= h_d;  area_q <= area_d;
            kern_q <= kern_d;  mag_max_q <= mag_max_d;  gray_q <= gray_d;  thresh_q <= thresh_d;
            in_cnt_q <= in_cnt_d;  x_q <= x_d;  fl_cnt_q <= fl_cnt_d;  ox_q <= ox_d;  oy_q <= oy_d;
            in_rdy_q <= in_rdy_d;  win1_q <= win1_d;  win2_q <= win2_d;
            v1_q <= v1_d;  bord1_q <= bord1_d;  last1_q <= last1_d;  gx_q <= gx_d;  gy_q <= gy_d;
            v2_q <= v2_d;  bord2_q <= bord2_d;  last2_q <= last2_d;  mag_q <= mag_d;
            out_q <= out_d;  out_vld_q <= out_vld_d;  done_q <= done_d;
        end
    end

    assign pixel_in_ready  = in_rdy_q;
    assign pixel_out       = out_q;
    assign pixel_out_valid = out_vld_q;
    assign frame_done      = done_q;
endmodule

// File: tb/tb_hw_accel_edge_detection_mk2.sv
// Directed bench for hw_accel_edge_detection_mk2: small frames with hand-computed interior results.
module tb_hw_accel_edge_detection_mk2;
    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cfg_img_width, cfg_img_height;
    logic [1:0]  cfg_kernel;
    logic        cfg_mag_max, cfg_gray_out;
    logic [7:0]  cfg_thresh, pixel_in, pixel_out;
    logic        pixel_in_valid, pixel_in_ready, pixel_out_valid, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outs[$];
    int out_cyc[$];
    int done_cnt = 0, done_at = 0, done_bad = 0, low_run = 0, last_low = 0;
    int img[64];
    int expv[64];
    int acc_cyc[64];

    hw_accel_edge_detection_mk2 dut (
        .clk(clk), .rst(rst),
        .cfg_img_width(cfg_img_width), .cfg_img_height(cfg_img_height),
        .cfg_kernel(cfg_kernel), .cfg_mag_max(cfg_mag_max), .cfg_gray_out(cfg_gray_out),
        .cfg_thresh(cfg_thresh), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
        .pixel_in_ready(pixel_in_ready), .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pixel_out_valid) begin
            outs.push_back(int'(pixel_out));
            out_cyc.push_back(cyc);
        end
        if (frame_done) begin
            done_cnt++;
            done_at = outs.size();
            if (!pixel_out_valid) done_bad++;
        end
        if (!pixel_in_ready) low_run++;
        else begin
            if (low_run > 0) last_low = low_run;
            low_run = 0;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int w, input int h, input int k, input int mx, input int gr, input int th);
        cfg_img_width = 11'(w);  cfg_img_height = 11'(h);
        cfg_kernel = 2'(k);  cfg_mag_max = mx[0];  cfg_gray_out = gr[0];  cfg_thresh = 8'(th);
        outs.delete();
        out_cyc.delete();
    endtask

    task automatic drive(input int n, input bit gaps, input bit chg);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (chg && idx >= 1) begin
                cfg_thresh = 8'd0;
                cfg_kernel = 2'd2;
            end
            if (gaps && $urandom_range(0, 2) == 0) pixel_in_valid = 1'b0;
            else begin
                pixel_in_valid = 1'b1;
                pixel_in = 8'(img[idx]);
                if (pixel_in_ready) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
            end
        end
        @(negedge clk);
        pixel_in_valid = 1'b0;
        chk("inputs_accepted", idx, n);
    endtask

    task automatic wait_done(input string tag);
        int base = done_cnt;
        int g = 0;
        while (done_cnt == base && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_frame_done_count"}, done_cnt - base, 1);
    endtask

    task automatic check_frame(input string tag, input int n);
        chk({tag, "_out_count"}, outs.size(), n);
        chk({tag, "_done_at_last"}, done_at, n);
        for (int k = 0; k < n; k++)
            if (k < outs.size()) chk($sformatf("%s_pix[%0d]", tag, k), outs[k], expv[k]);
    endtask

    task automatic set_exp(input int w, input int h, input int lo, input int hi, input int val);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                expv[y*w+x] = (y > 0 && y < h-1 && x > 0 && x < w-1 && x >= lo && x <= hi) ? val : 0;
    endtask

    initial begin
        int done_before;
        rst = 1'b1;
        pixel_in_valid = 1'b0;
        pixel_in = 8'd0;
        cfg(4, 4, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(pixel_in_ready), 1);
        chk("rst_out_valid", int'(pixel_out_valid), 0);
        chk("rst_out", int'(pixel_out), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        @(negedge clk);

        // 4x4 ramp p=x+4y, Sobel: |Gx|=8, |Gy|=32, L1=40 on the four interior pixels.
        for (int i = 0; i < 16; i++) img[i] = i;
        cfg(4, 4, 0, 0, 0, 0);
        drive(16, 0, 0);
        wait_done("ramp_bin");
        set_exp(4, 4, 0, 99, 255);
        check_frame("ramp_bin", 16);
        chk("done_without_valid", done_bad, 0);

        // Threshold equal to L1 (strict >) gives zeros; mid-frame cfg changes must be ignored.
        cfg(4, 4, 0, 0, 0, 40);
        drive(16, 0, 1);
        wait_done("ramp_eq_thresh");
        set_exp(4, 4, 0, 99, 0);
        check_frame("ramp_eq_thresh", 16);

        // Flat 5x3 Scharr gray: all zeros; latency and tail backpressure timing.
        for (int i = 0; i < 15; i++) img[i] = 8'h80;
        cfg(5, 3, 2, 0, 1, 0);
        drive(15, 0, 0);
        wait_done("flat");
        set_exp(5, 3, 0, 99, 0);
        check_frame("flat", 15);
        chk("ready_low_tail", last_low, 9);
        if (out_cyc.size() == 15) begin
            chk("first_out_latency", out_cyc[0], acc_cyc[6] + 3);
            chk("last_out_latency", out_cyc[14], acc_cyc[14] + 9);
        end

        // 3x3 single bright centre: symmetric window so Gx=Gy=0.
        for (int i = 0; i < 9; i++) img[i] = (i == 4) ? 255 : 0;
        cfg(3, 3, 0, 0, 1, 0);
        drive(9, 0, 0);
        wait_done("dot");
        set_exp(3, 3, 0, 99, 0);
        check_frame("dot", 9);

        // 8x8 vertical edge at x=4, Prewitt L1 gray: 765 saturates at x=3,4.
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) img[y*8+x] = (x >= 4) ? 255 : 0;
        cfg(8, 8, 1, 0, 1, 0);
        drive(64, 0, 0);
        wait_done("edge_prewitt");
        set_exp(8, 8, 3, 4, 255);
        check_frame("edge_prewitt", 64);

        // Same image, Sobel max binary thresh 254 (1020 > 254), random input gaps.
        cfg(8, 8, 0, 1, 0, 254);
        drive(64, 1, 0);
        wait_done("edge_sobel_gaps");
        check_frame("edge_sobel_gaps", 64);
        if (out_cyc.size() == 64)
            for (int k = 0; k < 55; k++)
                chk($sformatf("cadence[%0d]", k), out_cyc[k], acc_cyc[k+9] + 3);

        // Abort a frame mid-RUN with reset, then run a clean 4x4 Scharr L1 gray frame (16*2+16*8=160).
        for (int i = 0; i < 16; i++) img[i] = i;
        cfg(4, 4, 0, 0, 0, 0);
        done_before = done_cnt;
        drive(8, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_out_valid", int'(pixel_out_valid), 0);
        chk("midrst_in_ready", int'(pixel_in_ready), 1);
        chk("midrst_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_stale_done", done_cnt, done_before);
        cfg(4, 4, 2, 0, 1, 0);
        drive(16, 0, 0);
        wait_done("after_reset");
        set_exp(4, 4, 0, 99, 160);
        check_frame("after_reset", 16);
        chk("done_without_valid_final", done_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
